// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with a memory-ready handshake and a wait watchdog.
// Define MC_JUMP_EN to build the JUMP state for opcode 000010.
module mips_multicycle_control #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned WAIT_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
`ifdef MC_JUMP_EN
    StJump     = 4'd9,
`endif
    StTrap     = 4'd15
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
`ifdef MC_JUMP_EN
  localparam logic [5:0] OpJ     = 6'b000010;
`endif

  localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(WAIT_LIMIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              timeout;

  // A not-ready cycle that would bring the counter to the limit traps instead of waiting.
  assign wait_inc = wait_q + WAIT_W'(1);
  assign timeout  = (wait_inc == WaitMax);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    trap          = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_inc;
        end
      end

      StDecode: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OpRType:    state_d = StExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
`ifdef MC_JUMP_EN
          OpJ:        state_d = StJump;
`endif
          default:    state_d = StTrap;
        endcase
      end

      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OpLw) begin
          state_d = StMemRead;
        end else if (opcode == OpSw) begin
          state_d = StMemWrite;
        end else begin
          state_d = StTrap;
        end
      end

      StMemRead: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_inc;
        end
      end

      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StMemWrite: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end else if (timeout) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_inc;
        end
      end

      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = StRWb;
      end

      StRWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end

      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = StFetch;
      end

`ifdef MC_JUMP_EN
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
`endif

      StTrap: begin
        trap    = 1'b1;
        state_d = StTrap;
      end

      default: begin
        state_d = StTrap;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: randomized instruction streams against a per-cycle expected trace.
module tb_mips_multicycle_control;

  localparam int WaitLimit = 15;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, trap;
  logic [3:0] state;

  mips_multicycle_control #(
    .WAIT_LIMIT(WaitLimit),
    .WAIT_W    (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d       (i_or_d),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .instr_done   (instr_done),
    .trap         (trap),
    .state        (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic [5:0] op;
  } step_t;

  step_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  bit    trapped;

  logic [17:0] obs_ctl;
  assign obs_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                    instr_done, trap};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Expected control word straight from the per-state output table.
  function automatic logic [17:0] exp_ctl(input int st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, done, tr;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, done, tr} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mw = 1; iod = 1; done = rdy; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      9:  begin pw = 1; psrc = 2'b10; done = 1; end
      default: tr = 1;
    endcase
    return {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, done, tr};
  endfunction

  task automatic push(input int st, input logic rdy, input logic [5:0] op);
    q.push_back('{st: 4'(st), rdy: rdy, op: op});
  endtask

  // w not-ready cycles in a memory state, then completion or a watchdog trap.
  task automatic add_mem(input int st, input int w, input logic [5:0] op);
    for (int i = 0; i < w && i < WaitLimit; i++) push(st, 1'b0, op);
    if (w >= WaitLimit) begin
      push(15, 1'($urandom), op);
      trapped = 1;
    end else begin
      push(st, 1'b1, op);
    end
  endtask

  task automatic add_instr(input logic [5:0] op, input int fw, input int mw);
    add_mem(0, fw, 6'($urandom));
    if (trapped) return;
    push(1, 1'($urandom), op);
    case (op)
      6'b000000: begin push(6, 1'($urandom), op); push(7, 1'($urandom), op); end
      6'b100011: begin
        push(2, 1'($urandom), op);
        add_mem(3, mw, op);
        if (!trapped) push(4, 1'($urandom), op);
      end
      6'b101011: begin push(2, 1'($urandom), op); add_mem(5, mw, op); end
      6'b000100: push(8, 1'($urandom), op);
`ifdef MC_JUMP_EN
      6'b000010: push(9, 1'($urandom), op);
`endif
      default: begin push(15, 1'($urandom), op); trapped = 1; end
    endcase
  endtask

  // Aligned at posedge+1: drive, check at negedge, advance.
  task automatic run_q();
    step_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      opcode    = e.op;
      mem_ready = e.rdy;
      @(negedge clock);
      chk("state", 32'(state), 32'(e.st));
      chk("ctl", 32'(obs_ctl), 32'(exp_ctl(int'(e.st), e.rdy)));
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_trap", 32'(trap), 32'd0);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    trapped   = 0;
  endtask

  logic [5:0] ops [4];

  initial begin
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    trapped   = 0;
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'b000000;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ctl", 32'(obs_ctl), 32'(exp_ctl(0, 1'b0)));
    reset = 1'b0;

    // Directed: R, lw with 3 waits, sw, beq, all with mem_ready otherwise high.
    add_instr(6'b000000, 0, 0);
    add_instr(6'b100011, 0, 3);
    add_instr(6'b101011, 0, 0);
    add_instr(6'b000100, 0, 0);
    // One below the watchdog limit must still complete.
    add_instr(6'b000000, WaitLimit - 1, 0);
    add_instr(6'b100011, 0, WaitLimit - 1);
    run_q();

    // Randomized legal instruction stream.
    for (int n = 0; n < 40; n++) begin
      add_instr(ops[$urandom_range(0, 3)], $urandom_range(0, 4), $urandom_range(0, 4));
    end
    run_q();

    // Jump: completes with the feature, traps without it.
    add_instr(6'b000010, 0, 0);
    for (int i = 0; i < 3; i++) push(trapped ? 15 : 0, 1'b0, 6'b000010);
    run_q();
    do_reset();

    // Illegal opcode traps and stays trapped.
    add_instr(6'b111111, 1, 0);
    for (int i = 0; i < 20; i++) push(15, 1'($urandom), 6'($urandom));
    run_q();
    do_reset();

    // Watchdog in FETCH.
    add_instr(6'b000000, WaitLimit, 0);
    for (int i = 0; i < 3; i++) push(15, 1'b1, 6'b000000);
    run_q();
    do_reset();

    // Watchdog in MEM_WRITE.
    add_instr(6'b101011, 0, WaitLimit);
    for (int i = 0; i < 3; i++) push(15, 1'b1, 6'b101011);
    run_q();
    do_reset();

    // Reset during a pending store aborts the write at once.
    push(0, 1'b1, 6'b101011);
    push(1, 1'b1, 6'b101011);
    push(2, 1'b1, 6'b101011);
    run_q();
    mem_ready = 1'b0;
    #2;
    chk("sw_pending_write", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_write", 32'(mem_write), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    add_instr(6'b000000, 0, 0);
    run_q();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
